// File: rtl/platform_pkg.sv
// Shared platform definitions: peripheral Wishbone widths, UART_TX register
// offsets, status bit positions and the transmit FSM state type.
package platform_pkg;

  localparam int PERIPH_WB_AW = 16;
  localparam int PERIPH_WB_DW = 32;

  localparam logic [1:0] UART_TX_DATA_OFF   = 2'd0;
  localparam logic [1:0] UART_TX_STATUS_OFF = 2'd1;
  localparam logic [1:0] UART_TX_CTRL_OFF   = 2'd2;

  localparam int UART_TX_STAT_FULL_BIT   = 0;
  localparam int UART_TX_STAT_EMPTY_BIT  = 1;
  localparam int UART_TX_STAT_BUSY_BIT   = 2;
  localparam int UART_TX_STAT_OVF_BIT    = 3;
  localparam int UART_TX_CTRL_IRQ_EN_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle used on the peripheral crossbar.
// Handshake: a request is any cycle with cyc&stb (stall never asserted here); each request gets exactly one ack or err.
interface wishbone_if #(
  parameter int AW = platform_pkg::PERIPH_WB_AW,
  parameter int DW = platform_pkg::PERIPH_WB_DW
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            err;
  logic            stall;
  logic [DW-1:0]   rdata;

  modport MASTER (output cyc, stb, we, addr, wdata, sel,
                  input  ack, err, stall, rdata);
  modport SLAVE  (input  cyc, stb, we, addr, wdata, sel,
                  output ack, err, stall, rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART transmitter.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Wishbone UART transmitter: TXDATA/STATUS/CTRL registers, TX FIFO and 8N1 bit FSM.
// Interrupt logic is present only when UART_TX_IRQ_EN is defined.
module uart_tx_periph
  import platform_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wishbone_if.SLAVE wb_if,
  output logic      tx_o,
  output logic      irq_o
);

  uart_tx_state_t state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    divl_q, divl_d;
  logic           tx_q, tx_d;
  logic [15:0]    div_q, div_d;
  logic           ovf_q, ovf_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;

  logic       req, addr_ok, wr, rd, push_req, pop, busy, irq_en;
  logic [1:0] off;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_data;
  logic [31:0] status_word, ctrl_word;
  logic       unused_wb;

  assign req      = wb_if.cyc & wb_if.stb;
  assign off      = wb_if.addr[1:0];
  assign addr_ok  = (wb_if.addr[PERIPH_WB_AW-1:2] == '0) && (off != 2'd3);
  assign wr       = req & addr_ok & wb_if.we;
  assign rd       = req & addr_ok & ~wb_if.we;
  assign push_req = wr & (off == UART_TX_DATA_OFF) & wb_if.sel[0];
  assign busy     = (state_q != IDLE);
  assign unused_wb = ^{wb_if.wdata[31:17], wb_if.wdata[16], wb_if.sel[3], wb_if.sel[2]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .data_i  (wb_if.wdata[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    status_word = '0;
    status_word[UART_TX_STAT_FULL_BIT]  = fifo_full;
    status_word[UART_TX_STAT_EMPTY_BIT] = fifo_empty;
    status_word[UART_TX_STAT_BUSY_BIT]  = busy;
    status_word[UART_TX_STAT_OVF_BIT]   = ovf_q;
    ctrl_word = {15'd0, irq_en, div_q};
  end

  // Register file and single-cycle Wishbone response.
  always_comb begin
    div_d   = div_q;
    ovf_d   = ovf_q;
    rdata_d = '0;
    ack_d   = req & addr_ok;
    err_d   = req & ~addr_ok;
    if (wr && off == UART_TX_CTRL_OFF) begin
      if (wb_if.sel[0]) div_d[7:0]  = wb_if.wdata[7:0];
      if (wb_if.sel[1]) div_d[15:8] = wb_if.wdata[15:8];
    end
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr && off == UART_TX_STATUS_OFF && wb_if.sel[0] &&
                 wb_if.wdata[UART_TX_STAT_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
    if (rd) begin
      case (off)
        UART_TX_STATUS_OFF: rdata_d = status_word;
        UART_TX_CTRL_OFF:   rdata_d = ctrl_word;
        default:            rdata_d = '0;
      endcase
    end
  end

  // Bit FSM: each state holds for divl+1 clocks; divisor is captured at every pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    divl_d  = divl_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          divl_d  = div_q;
          baud_d  = div_q;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == 16'd0) begin
          baud_d  = divl_q;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = divl_q;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            divl_d  = div_q;
            baud_d  = div_q;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      divl_q  <= DIV_RESET;
      tx_q    <= 1'b1;
      div_q   <= DIV_RESET;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      divl_q  <= divl_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && off == UART_TX_CTRL_OFF && wb_if.sel[2])
        irq_en_q <= wb_if.wdata[UART_TX_CTRL_IRQ_EN_BIT];
      irq_q <= irq_en_q & ((fifo_empty & ~busy) | ovf_q);
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  // A master that drops cyc abandons its outstanding response.
  assign wb_if.ack   = ack_q & wb_if.cyc;
  assign wb_if.err   = err_q & wb_if.cyc;
  assign wb_if.stall = 1'b0;
  assign wb_if.rdata = rdata_q;
  assign tx_o        = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: register access, 8N1 framing against a frame-level
// model, FIFO overflow, bus errors, interrupt (UART_TX_IRQ_EN) and async reset.
module tb_uart_tx_periph;
  import platform_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic irq;
  int   checks = 0;
  int   failures = 0;

  logic       tx_log[$];
  bit         rec_en = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_div_q[$];

`ifdef UART_TX_IRQ_EN
  localparam logic        IRQ_ON   = 1'b1;
  localparam logic [31:0] CTRL_IRQ = 32'h0001_0003;
`else
  localparam logic        IRQ_ON   = 1'b0;
  localparam logic [31:0] CTRL_IRQ = 32'h0000_0003;
`endif

  wishbone_if #(.AW(PERIPH_WB_AW), .DW(PERIPH_WB_DW)) wb ();

  uart_tx_periph #(.FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb_if (wb),
    .tx_o  (tx),
    .irq_o (irq)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rec_en) tx_log.push_back(tx);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we_v, input logic [15:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output logic ack_v, output logic err_v,
                         output logic [31:0] rd_v);
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we_v;
    wb.addr = a; wb.wdata = wd; wb.sel = s;
    @(posedge clk); #1;
    ack_v = wb.ack; err_v = wb.err; rd_v = wb.rdata;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level scoreboard: one contiguous run of 8N1 frames from the first start bit.
  task automatic analyze_log(input string tag);
    int start, base, bp, mism, bi;
    logic [7:0] b, obs;
    logic e, idle;
    start = -1;
    for (int i = 0; i < tx_log.size(); i++)
      if (tx_log[i] === 1'b0) begin start = i; break; end
    checks++;
    if (start < 0) begin
      failures++;
      $display("FAIL %s_start: no start bit seen, expected %0d frames", tag, exp_q.size());
    end else begin
      base = start;
      for (int f = 0; f < exp_q.size(); f++) begin
        bp = exp_div_q[f] + 1;
        b  = exp_q[f];
        checks++;
        if (base + 10 * bp > tx_log.size()) begin
          failures++;
          $display("FAIL %s_len: frame %0d truncated, have %0d samples need %0d",
                   tag, f, tx_log.size(), base + 10 * bp);
          break;
        end
        for (int j = 0; j < 8; j++) obs[j] = tx_log[base + (j + 1) * bp + bp / 2];
        checks++;
        if (obs !== b) begin
          failures++;
          $display("FAIL %s_byte: frame %0d got %h expected %h", tag, f, obs, b);
        end
        mism = 0;
        for (int k = 0; k < 10 * bp; k++) begin
          bi = k / bp;
          if (bi == 0) e = 1'b0;
          else if (bi == 9) e = 1'b1;
          else e = b[bi - 1];
          if (tx_log[base + k] !== e) mism++;
        end
        checks++;
        if (mism != 0) begin
          failures++;
          $display("FAIL %s_wave: frame %0d has %0d wrong samples expected 0 (div %0d)",
                   tag, f, mism, bp - 1);
        end
        base += 10 * bp;
      end
      idle = (base < tx_log.size()) ? tx_log[base] : 1'bx;
      checks++;
      if (idle !== 1'b1) begin
        failures++;
        $display("FAIL %s_idle: line after last frame got %b expected 1", tag, idle);
      end
    end
    tx_log.delete(); exp_q.delete(); exp_div_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic a, e; logic [31:0] r;
    #1 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if ({wb.ack, wb.err, wb.stall} !== 3'b000) begin
      failures++; $display("FAIL reset_bus: ack/err/stall got %b expected 000", {wb.ack, wb.err, wb.stall}); end
    checks++; if (wb.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", wb.rdata); end
    wait_clks(3);
    rst = 1'b0;
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if ({a, e, r} !== {2'b10, 32'h2}) begin
      failures++; $display("FAIL reset_status: ack=%b err=%b rdata=%h expected 1 0 00000002", a, e, r); end
    wb_xfer(1'b0, 16'h2, 32'h0, 4'hF, a, e, r);
    checks++; if ({a, e, r} !== {2'b10, 32'h363}) begin
      failures++; $display("FAIL reset_ctrl: ack=%b err=%b rdata=%h expected 1 0 00000363", a, e, r); end
  endtask

  task automatic test_single_frame();
    logic a, e; logic [31:0] r;
    wb_xfer(1'b1, 16'h2, 32'h3, 4'hF, a, e, r);
    tx_log.delete(); rec_en = 1'b1;
    wb_xfer(1'b1, 16'h0, 32'hA5, 4'h1, a, e, r);
    exp_q.push_back(8'hA5); exp_div_q.push_back(3);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL frame_ack: got %b expected 1", a); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL frame_lat1: tx got %b expected 1", tx); end
    wait_clks(1);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL frame_lat2: tx got %b expected 0", tx); end
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h6) begin failures++; $display("FAIL frame_busy: status got %h expected 6", r); end
    wait_clks(36);
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h6) begin failures++; $display("FAIL frame_stop: status got %h expected 6", r); end
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL frame_done: status got %h expected 2", r); end
    wait_clks(4);
    rec_en = 1'b0;
    analyze_log("a5");
  endtask

  task automatic test_back_to_back();
    logic a, e; logic [31:0] r;
    tx_log.delete(); rec_en = 1'b1;
    wb_xfer(1'b1, 16'h0, 32'h3C, 4'h1, a, e, r);
    wb_xfer(1'b1, 16'h0, 32'hC3, 4'h1, a, e, r);
    wb_xfer(1'b1, 16'h2, 32'h1, 4'h3, a, e, r);
    wb_xfer(1'b1, 16'h0, 32'h5A, 4'h1, a, e, r);
    exp_q = '{8'h3C, 8'hC3, 8'h5A};
    exp_div_q = '{3, 1, 1};
    wait_clks(40 + 20 + 20 + 20);
    rec_en = 1'b0;
    analyze_log("b2b");
  endtask

  task automatic test_overflow();
    logic a, e; logic [31:0] r;
    logic [7:0] d[9];
    int acks, errs;
    wb_xfer(1'b1, 16'h2, 32'h3, 4'h3, a, e, r);
    tx_log.delete(); rec_en = 1'b1;
    wb_xfer(1'b1, 16'h0, 32'h11, 4'h1, a, e, r);
    exp_q.push_back(8'h11); exp_div_q.push_back(3);
    for (int i = 0; i < 9; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin exp_q.push_back(d[i]); exp_div_q.push_back(3); end
    acks = 0; errs = 0;
    wb.cyc = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        if (wb.ack === 1'b1) acks++;
        if (wb.err === 1'b1) errs++;
      end
      if (i < 9) begin
        wb.stb = 1'b1; wb.we = 1'b1; wb.addr = 16'h0; wb.wdata = {24'h0, d[i]}; wb.sel = 4'h1;
      end else begin
        wb.stb = 1'b0; wb.we = 1'b0;
      end
    end
    wb.cyc = 1'b0;
    checks++; if (acks !== 9 || errs !== 0) begin
      failures++; $display("FAIL ovf_acks: acks=%0d errs=%0d expected 9 0", acks, errs); end
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'hD) begin failures++; $display("FAIL ovf_set: status got %h expected d", r); end
    wb_xfer(1'b1, 16'h1, 32'h8, 4'h1, a, e, r);
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h5) begin failures++; $display("FAIL ovf_clr: status got %h expected 5", r); end
    wait_clks(9 * 40 + 10);
    rec_en = 1'b0;
    analyze_log("ovf");
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL ovf_drain: status got %h expected 2", r); end
  endtask

  task automatic test_err();
    logic a, e; logic [31:0] r;
    logic [15:0] bad[4];
    logic [4:0] wes;
    bad = '{16'h0003, 16'h0010, 16'h0012, 16'h0013};
    wes = 5'b00101;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(wes[i], bad[i], 32'hFF, 4'hF, a, e, r);
      checks++; if ({a, e, r} !== {2'b01, 32'h0}) begin
        failures++; $display("FAIL err_%h: ack=%b err=%b rdata=%h expected 0 1 00000000", bad[i], a, e, r); end
    end
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL err_nopush: status got %h expected 2", r); end
  endtask

  task automatic test_random();
    logic a, e; logic [31:0] r;
    int div, n;
    logic [7:0] b;
    for (int round = 0; round < 4; round++) begin
      div = $urandom_range(0, 4);
      n   = $urandom_range(1, 3);
      wb_xfer(1'b1, 16'h2, {16'h0, 16'(div)}, 4'h3, a, e, r);
      tx_log.delete(); rec_en = 1'b1;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b); exp_div_q.push_back(div);
        wb_xfer(1'b1, 16'h0, {24'h0, b}, 4'h1, a, e, r);
      end
      wait_clks(n * 10 * (div + 1) + 20);
      rec_en = 1'b0;
      analyze_log($sformatf("rnd%0d", round));
    end
  endtask

  task automatic test_irq();
    logic a, e; logic [31:0] r;
    wb_xfer(1'b1, 16'h2, 32'h0001_0003, 4'h7, a, e, r);
    wait_clks(2);
    checks++; if (irq !== IRQ_ON) begin failures++; $display("FAIL irq_idle: got %b expected %b", irq, IRQ_ON); end
    wb_xfer(1'b0, 16'h2, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== CTRL_IRQ) begin failures++; $display("FAIL irq_ctrl: got %h expected %h", r, CTRL_IRQ); end
    wb_xfer(1'b1, 16'h0, 32'h42, 4'h1, a, e, r);
    wait_clks(41);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_busy: got %b expected 0", irq); end
    wait_clks(1);
    checks++; if (irq !== IRQ_ON) begin failures++; $display("FAIL irq_rise: got %b expected %b", irq, IRQ_ON); end
  endtask

  task automatic test_reset_mid_frame();
    logic a, e; logic [31:0] r;
    int zeros;
    wb_xfer(1'b1, 16'h0, 32'h00, 4'h1, a, e, r);
    wb_xfer(1'b1, 16'h0, 32'h55, 4'h1, a, e, r);
    wb_xfer(1'b1, 16'h0, 32'h77, 4'h1, a, e, r);
    wait_clks(8);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_data: tx got %b expected 0", tx); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1 || irq !== 1'b0) begin
      failures++; $display("FAIL mid_rst: tx=%b irq=%b expected 1 0", tx, irq); end
    wait_clks(2);
    rst = 1'b0;
    wb_xfer(1'b0, 16'h1, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL mid_status: got %h expected 2", r); end
    wb_xfer(1'b0, 16'h2, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h363) begin failures++; $display("FAIL mid_ctrl: got %h expected 363", r); end
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      wait_clks(1);
      if (tx !== 1'b1) zeros++;
    end
    checks++; if (zeros !== 0) begin failures++; $display("FAIL mid_quiet: %0d non-idle samples expected 0", zeros); end
  endtask

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.addr = '0; wb.wdata = '0; wb.sel = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_err();
    test_random();
    test_irq();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
